// File: rtl/rr_burst_arbiter_if.sv
// Requester/resource bus of the packet-level round-robin arbiter.
interface rr_burst_arbiter_if #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          res_ready;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          beat_fire;
  logic          forced_release;
  logic [CW-1:0] beat_cnt;

  // Requester/resource side: drives requests and readiness, observes grants.
  modport master (
    output req, last, res_ready,
    input  grant, grant_valid, grant_id, beat_fire, forced_release, beat_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, last, res_ready,
    output grant, grant_valid, grant_id, beat_fire, forced_release, beat_cnt
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester per packet onto a shared
// single-beat-per-cycle resource, with a per-grant burst limit.
module rr_burst_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  rr_burst_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = IW + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          forced_q, forced_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] next_ptr;
  logic [IW-1:0] base;
  logic [IW-1:0] win_id;
  logic [SW-1:0] scan_idx;
  logic          win_found;
  logic          fire;
  logic          rel_last;
  logic          rel_max;
  logic          abandon;

  // Priority pointer just past the current holder, wrapping at N.
  assign next_ptr = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
  // On release the freshly advanced pointer is used in the same cycle.
  assign base     = (state_q == BUSY) ? next_ptr : ptr_q;

  assign fire     = valid_q & bus.req[id_q] & bus.res_ready;
  assign rel_last = fire & bus.last[id_q];
  assign rel_max  = fire & (cnt_q == CW'(MAX_BURST - 1));
  assign abandon  = ~bus.req[id_q];

  // Round-robin scan of req starting at base, modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan_idx = SW'(base) + SW'(k);
      if (scan_idx >= SW'(N)) scan_idx = scan_idx - SW'(N);
      if (!win_found && bus.req[scan_idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = N'(1) << win_id;
          id_d    = win_id;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (rel_last || rel_max || abandon) begin
          ptr_d    = next_ptr;
          forced_d = rel_max & ~rel_last;
          cnt_d    = '0;
          if (win_found) begin
            grant_d = N'(1) << win_id;
            id_d    = win_id;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
          end
        end else if (fire) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      forced_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      forced_q <= forced_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.grant_valid    = valid_q;
  assign bus.grant_id       = id_q;
  assign bus.beat_fire      = fire;
  assign bus.forced_release = forced_q;
  assign bus.beat_cnt       = cnt_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed vector tables (N=4 and N=3 instances),
// an asynchronous reset sequence and a model-driven random run.
module tb_rr_burst_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.N(4), .MAX_BURST(8)) bus4 ();
  rr_burst_arbiter_if #(.N(3), .MAX_BURST(3)) bus3 ();

  rr_burst_arbiter #(.N(4), .MAX_BURST(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  rr_burst_arbiter #(.N(3), .MAX_BURST(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic       fire;
    logic       forced;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    obs_t       exp;
  } vec_t;

  obs_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] last, input logic rdy,
                              input logic [3:0] g, input logic [1:0] id, input logic fire,
                              input logic forced, input logic [3:0] cnt);
    vec_t v;
    v.req = req; v.last = last; v.rdy = rdy;
    v.exp.grant = g; v.exp.id = id; v.exp.valid = (g != 4'd0);
    v.exp.fire = fire; v.exp.forced = forced; v.exp.cnt = cnt;
    return v;
  endfunction

  function automatic obs_t sample(input bit sel3);
    obs_t o;
    if (sel3) begin
      o.grant = {1'b0, bus3.grant}; o.id = bus3.grant_id; o.valid = bus3.grant_valid;
      o.fire = bus3.beat_fire; o.forced = bus3.forced_release; o.cnt = {2'b00, bus3.beat_cnt};
    end else begin
      o.grant = bus4.grant; o.id = bus4.grant_id; o.valid = bus4.grant_valid;
      o.fire = bus4.beat_fire; o.forced = bus4.forced_release; o.cnt = bus4.beat_cnt;
    end
    return o;
  endfunction

  task automatic drive(input bit sel3, input logic [3:0] req, input logic [3:0] last, input logic rdy);
    if (sel3) begin
      bus3.req = req[2:0]; bus3.last = last[2:0]; bus3.res_ready = rdy;
    end else begin
      bus4.req = req; bus4.last = last; bus4.res_ready = rdy;
    end
  endtask

  task automatic check(input bit sel3, input string nm);
    obs_t got, exp;
    exp = sb_q.pop_front();
    got = sample(sel3);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b fire=%b forced=%b cnt=%0d, expected grant=%b id=%0d valid=%b fire=%b forced=%b cnt=%0d",
               nm, got.grant, got.id, got.valid, got.fire, got.forced, got.cnt,
               exp.grant, exp.id, exp.valid, exp.fire, exp.forced, exp.cnt);
    end
  endtask

  task automatic run_vec(input bit sel3, input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(sel3, v.req, v.last, v.rdy);
    sb_q.push_back(v.exp);
    @(negedge clk);
    check(sel3, nm);
  endtask

  // Reference model state for the random run (N=4, MAX_BURST=8).
  int m_holder;
  int m_ptr;
  int m_cnt;
  bit m_forced;

  function automatic int pick(input int base, input logic [3:0] req);
    for (int k = 0; k < 4; k++) begin
      if (req[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic obs_t predict(input logic [3:0] req, input logic rdy);
    obs_t o;
    o.grant  = (m_holder >= 0) ? 4'(1 << m_holder) : 4'd0;
    o.id     = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
    o.valid  = (m_holder >= 0);
    o.fire   = (m_holder >= 0) && req[m_holder] && rdy;
    o.forced = m_forced;
    o.cnt    = 4'(m_cnt);
    return o;
  endfunction

  task automatic model_step(input logic [3:0] req, input logic [3:0] last, input logic rdy);
    bit f, rel;
    m_forced = 1'b0;
    if (m_holder < 0) begin
      m_holder = pick(m_ptr, req);
      m_cnt = 0;
    end else begin
      f = req[m_holder] && rdy;
      rel = 1'b0;
      if (f && last[m_holder]) rel = 1'b1;
      else if (f && m_cnt == 7) begin rel = 1'b1; m_forced = 1'b1; end
      else if (!req[m_holder]) rel = 1'b1;
      else if (f) m_cnt++;
      if (rel) begin
        m_ptr = (m_holder + 1) % 4;
        m_holder = pick(m_ptr, req);
        m_cnt = 0;
      end
    end
  endtask

  vec_t t4[$];
  vec_t t3[$];

  initial begin
    obs_t zero;
    zero = '0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 4'd0, 4'd0, 1'b0);

    // N=4: single-beat round robin, packet hold, abandon after re-win,
    // IDLE arbitration from ptr=3, forced release, abandon to next pending.
    for (int i = 0; i < 7; i++)
      t4.push_back(mk(4'hF, 4'hF, 1'b1,
                      (i == 0) ? 4'd0 : 4'(1 << ((i - 1) % 4)),
                      (i == 0) ? 2'd0 : 2'((i - 1) % 4),
                      (i != 0), 1'b0, 4'd0));
    t4.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'd0));
    t4.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 4'd1));
    t4.push_back(mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'd1));
    t4.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'd2));
    t4.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0, 4'd0));
    t4.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0));
    t4.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0));
    for (int k = 0; k < 8; k++)
      t4.push_back(mk(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 4'(k)));
    t4.push_back(mk(4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 4'd0));
    t4.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'd0));
    t4.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b0, 4'd0));

    // N=3: pointer wrap at 3, not 4.
    t3.push_back(mk(4'b010, 4'b010, 1'b1, 4'b000, 2'd0, 1'b0, 1'b0, 4'd0));
    t3.push_back(mk(4'b011, 4'b010, 1'b1, 4'b010, 2'd1, 1'b1, 1'b0, 4'd0));
    t3.push_back(mk(4'b011, 4'b001, 1'b1, 4'b001, 2'd0, 1'b1, 1'b0, 4'd0));
    t3.push_back(mk(4'b101, 4'b010, 1'b1, 4'b010, 2'd1, 1'b0, 1'b0, 4'd0));
    t3.push_back(mk(4'b110, 4'b100, 1'b1, 4'b100, 2'd2, 1'b1, 1'b0, 4'd0));
    t3.push_back(mk(4'b000, 4'b000, 1'b0, 4'b010, 2'd1, 1'b0, 1'b0, 4'd0));
    t3.push_back(mk(4'b000, 4'b000, 1'b0, 4'b000, 2'd0, 1'b0, 1'b0, 4'd0));

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    sb_q.push_back(zero); check(1'b0, "reset4");
    sb_q.push_back(zero); check(1'b1, "reset3");
    rst = 1'b0;

    foreach (t4[i]) run_vec(1'b0, t4[i], $sformatf("n4_vec%0d", i));
    foreach (t3[i]) run_vec(1'b1, t3[i], $sformatf("n3_vec%0d", i));

    // Asynchronous reset while requester 3 holds the grant mid-packet.
    @(posedge clk);
    #1;
    drive(1'b0, 4'b1000, 4'b0000, 1'b1);
    #1;
    sb_q.push_back(mk(4'd0, 4'd0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 4'd0).exp);
    check(1'b0, "pre_reset_hold");
    #1 rst = 1'b1;
    #1;
    sb_q.push_back(zero);
    check(1'b0, "async_reset_drop");
    drive(1'b0, 4'b0110, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_vec(1'b0, mk(4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0, 4'd0), "post_reset_ptr0");

    // Random run against the reference model.
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_holder = -1; m_ptr = 0; m_cnt = 0; m_forced = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rq, ls;
      logic       rd;
      for (int b = 0; b < 4; b++) begin
        rq[b] = ($urandom_range(0, 99) < 80);
        ls[b] = ($urandom_range(0, 5) == 0);
      end
      rd = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      drive(1'b0, rq, ls, rd);
      sb_q.push_back(predict(rq, rd));
      @(negedge clk);
      check(1'b0, $sformatf("rand%0d", c));
      model_step(rq, ls, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
